retire_trace_unit: RTL and testbench

Retirement trace emitter in the writeback stage of `riscv_cpu`. For each retiring instruction it captures PC, encoding, register write and store effect into a FIFO. It presents those records on a valid/ready port to an external checker or golden model, so verification no longer probes `my_reg_file`/`data_mem` hierarchically. It also provides backpressure, drop detection and a halt-drain handshake.

---
 rtl/retire_trace_unit.sv | 159 +++++++++++++++
 tb/tb_retire_trace_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_unit.sv
// Retirement trace emitter: one record per retiring instruction, queued and presented on a valid/ready port.
// Store-data capture is optional via TRACE_MEMDATA_EN (default build omits it and ties tr_mem_data to 0).
module retire_trace_unit #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_instr,
    input  logic        wb_rd_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_rd_data,
    input  logic        wb_mem_we,
    input  logic [31:0] wb_mem_addr,
    input  logic [31:0] wb_mem_data,
    input  logic        halt_in,
    output logic        stall_req,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [1:0]  tr_kind,
    output logic [31:0] tr_pc,
    output logic [31:0] tr_instr,
    output logic [4:0]  tr_rd,
    output logic [31:0] tr_data,
    output logic [31:0] tr_mem_data,
    output logic [31:0] tr_seq,
    output logic [31:0] retired_count,
    output logic        overflow,
    output logic        drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] seq;
`ifdef TRACE_MEMDATA_EN
        logic [31:0] mem_data;
`endif
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic          full, empty, run, push, pop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        run   = (state_q == ST_RUN);
        pop   = !empty && tr_ready;
        push  = wb_valid && run && (!full || pop);
    end

    // Stores dominate register writes; x0 writes carry no architectural effect.
    always_comb begin
        wr_rec       = '0;
        wr_rec.pc    = wb_pc;
        wr_rec.instr = wb_instr;
        wr_rec.seq   = seq_q;
        if (wb_mem_we) begin
            wr_rec.kind = KIND_STORE;
            wr_rec.data = wb_mem_addr;
`ifdef TRACE_MEMDATA_EN
            wr_rec.mem_data = wb_mem_data;
`endif
        end else if (wb_rd_we && (wb_rd != 5'd0)) begin
            wr_rec.kind = KIND_REG;
            wr_rec.rd   = wb_rd;
            wr_rec.data = wb_rd_data;
        end else begin
            wr_rec.kind = KIND_NONE;
        end
    end

`ifndef TRACE_MEMDATA_EN
    logic unused_mem_data;
    assign unused_mem_data = ^wb_mem_data;
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        seq_d    = push ? seq_q + 32'd1 : seq_q;
        ovf_d    = ovf_q | (wb_valid && run && full && !pop);
    end

    // DRAIN completes on the count after this cycle's pop; no pushes happen there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (halt_in) state_d = ST_DRAIN;
            ST_DRAIN: if (count_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

    // Outputs are forced to zero while empty so stale entries never leak after reset.
    always_comb begin
        head          = tr_valid ? mem_q[rd_ptr_q] : '0;
        tr_valid      = !empty;
        stall_req     = full;
        tr_kind       = head.kind;
        tr_pc         = head.pc;
        tr_instr      = head.instr;
        tr_rd         = head.rd;
        tr_data       = head.data;
        tr_seq        = head.seq;
`ifdef TRACE_MEMDATA_EN
        tr_mem_data   = head.mem_data;
`else
        tr_mem_data   = 32'd0;
`endif
        retired_count = seq_q;
        overflow      = ovf_q;
        drained       = (state_q == ST_DONE);
    end
endmodule

// File: tb/tb_retire_trace_unit.sv
// Bench for retire_trace_unit: directed scenarios plus random traffic against a queue-based model.
module tb_retire_trace_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_rd_we, wb_mem_we, halt_in, tr_ready;
    logic [31:0] wb_pc, wb_instr, wb_rd_data, wb_mem_addr, wb_mem_data;
    logic [4:0]  wb_rd;
    logic        stall_req, tr_valid, overflow, drained;
    logic [1:0]  tr_kind;
    logic [31:0] tr_pc, tr_instr, tr_data, tr_mem_data, tr_seq, retired_count;
    logic [4:0]  tr_rd;

    always #5 clk = ~clk;

    retire_trace_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd_we(wb_rd_we), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
        .wb_mem_we(wb_mem_we), .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
        .halt_in(halt_in), .stall_req(stall_req),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
        .tr_pc(tr_pc), .tr_instr(tr_instr), .tr_rd(tr_rd), .tr_data(tr_data),
        .tr_mem_data(tr_mem_data), .tr_seq(tr_seq),
        .retired_count(retired_count), .overflow(overflow), .drained(drained)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] md;
        logic [31:0] seq;
    } rec_t;

    rec_t        q[$];
    int unsigned m_seq;
    bit          m_ovf, m_halted, m_done;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq    = 0;
        m_ovf    = 0;
        m_halted = 0;
        m_done   = 0;
    endtask

    function automatic rec_t make_rec();
        rec_t r;
        r.pc    = wb_pc;
        r.instr = wb_instr;
        r.seq   = m_seq;
        r.rd    = 5'd0;
        r.data  = 32'd0;
        r.md    = 32'd0;
        if (wb_mem_we) begin
            r.kind = 2'd2;
            r.data = wb_mem_addr;
`ifdef TRACE_MEMDATA_EN
            r.md = wb_mem_data;
`endif
        end else if (wb_rd_we && wb_rd != 0) begin
            r.kind = 2'd1;
            r.rd   = wb_rd;
            r.data = wb_rd_data;
        end else begin
            r.kind = 2'd0;
        end
        return r;
    endfunction

    // Checks current outputs, advances the model by one clock, then steps past the edge.
    task automatic tick();
        rec_t h;
        bit   pop;
        if (!rst) model_reset();
        check("tr_valid", tr_valid, q.size() != 0);
        check("stall_req", stall_req, q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("drained", drained, m_done);
        check("retired_count", retired_count, m_seq);
        if (q.size() != 0) begin
            h = q[0];
            check("tr_kind", tr_kind, h.kind);
            check("tr_pc", tr_pc, h.pc);
            check("tr_instr", tr_instr, h.instr);
            check("tr_rd", tr_rd, h.rd);
            check("tr_data", tr_data, h.data);
            check("tr_mem_data", tr_mem_data, h.md);
            check("tr_seq", tr_seq, h.seq);
        end else if (!rst) begin
            check("rst_tr_kind", tr_kind, 0);
            check("rst_tr_pc", tr_pc, 0);
            check("rst_tr_instr", tr_instr, 0);
            check("rst_tr_rd", tr_rd, 0);
            check("rst_tr_data", tr_data, 0);
            check("rst_tr_mem_data", tr_mem_data, 0);
            check("rst_tr_seq", tr_seq, 0);
        end
        if (rst) begin
            pop = (q.size() != 0) && tr_ready;
            if (pop) void'(q.pop_front());
            if (!m_halted) begin
                if (wb_valid) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(make_rec());
                        m_seq++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (halt_in) m_halted = 1;
            end else if (!m_done && q.size() == 0) begin
                m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic rd_we,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic mem_we,
                         input logic [31:0] addr, input logic [31:0] mdata);
        wb_valid    = 1'b1;
        wb_pc       = pc;
        wb_instr    = instr;
        wb_rd_we    = rd_we;
        wb_rd       = rd;
        wb_rd_data  = rdata;
        wb_mem_we   = mem_we;
        wb_mem_addr = addr;
        wb_mem_data = mdata;
    endtask

    task automatic drive_random();
        drive($urandom, $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
              ($urandom_range(0, 3) == 0), $urandom, $urandom);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        wb_valid = 1'b0;
        halt_in  = 1'b0;
        tr_ready = 1'b0;
        #1;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        halt_in = 1'b0;
        tr_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b0;
        #1;
        reset_dut();

        // addi, nop to x0, store
        drive(32'h0, 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 32'd0);
        tick();
        drive(32'h4, 32'h00000013, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        drive(32'h8, 32'h00f02823, 1'b0, 5'd0, 32'd0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        wb_valid = 1'b0;
        tr_ready = 1'b1;
        repeat (4) tick();

        // Fill to full, overflow on the 9th, then drain in order
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            drive_random();
            tick();
        end
        wb_valid = 1'b0;
        tr_ready = 1'b1;
        repeat (DEPTH + 1) tick();

        // Full FIFO with simultaneous push and pop
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            drive_random();
            tick();
        end
        tr_ready = 1'b1;
        drive_random();
        tick();
        wb_valid = 1'b0;
        tr_ready = 1'b0;
        tick();

        // Halt with a retire in the same cycle, then drain
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
        end
        halt_in = 1'b1;
        drive_random();
        tick();
        halt_in = 1'b0;
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_random();
            tick();
        end
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;

        // Halt on an empty FIFO: DRAIN then DONE
        reset_dut();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        repeat (3) tick();

        // Random traffic, halting late, then a reset with records pending
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) drive_random();
            else wb_valid = 1'b0;
            tr_ready = ($urandom_range(0, 9) < 6);
            halt_in  = (i > 300) && ($urandom_range(0, 49) == 0);
            tick();
        end
        halt_in = 1'b0;
        reset_dut();
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_random();
            tick();
        end
        wb_valid = 1'b0;
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
